tl_ul_arbiter: RTL and testbench
================================

# tl_ul_arbiter

Two-master TileLink-UL arbiter that shares one downstream TL-UL A/D channel pair between requesters. Master 0 is the core BIU port and master 1 is an auxiliary master (debug or DMA). The block sits between the core's `core_o_tl_*` / `core_i_tl_*` bundle and the SoC crossbar. It allows exactly one outstanding transaction in total, uses round-robin grant, and routes each D response back to the master that issued the matching A request.

## Interface
Parameters:
- `TIMEOUT`, default 256: D-response watchdog limit in cycles. Used only with `TL_ARB_TIMEOUT_EN`. Legal range 2..65535.

Ports:
- `clk`  in  1  clock. All logic is rising-edge.
- `rst`  in  1  reset. Asynchronous assert, active-low (0 = reset). Synchronous deassert is provided externally.
- `arb_i_mN_tl_a_{opcode,param,size,source,address,mask,data,corrupt}`  in  `TL_A_WIDTH_*`  master N A-channel fields, N = 0,1.
- `arb_i_mN_tl_a_valid`  in  1  master N A valid.
- `arb_o_mN_tl_a_ready`  out  1  master N A ready.
- `arb_o_mN_tl_d_{opcode,param,size,source,sink,denied,data,corrupt}`  out  `TL_D_WIDTH_*`  master N D-channel fields.
- `arb_o_mN_tl_d_valid`  out  1  master N D valid.
- `arb_i_mN_tl_d_ready`  in  1  master N D ready.
- `arb_o_tl_a_*`, `arb_o_tl_a_valid`, `arb_i_tl_a_ready`  downstream A channel.
- `arb_i_tl_d_*`, `arb_i_tl_d_valid`, `arb_o_tl_d_ready`  downstream D channel.

## Operation
State machine states: IDLE, A_SEND, D_WAIT.

- **IDLE**
  - If any `mN_a_valid` is high, latch `grant` and go to A_SEND.
  - Tie: the master not granted last wins. The round-robin pointer `last` resets to 1, so m0 wins the first tie.
  - No A ready is asserted to any master.
  - `arb_o_tl_d_ready` = 1. Any stray downstream D beat is accepted and discarded; it is not forwarded.
- **A_SEND**
  - Downstream A fields and valid are a pure mux of the granted master's A bundle.
  - `arb_o_m{grant}_tl_a_ready` = `arb_i_tl_a_ready`. The other master's ready is 0.
  - On A fire (valid & ready): go to D_WAIT.
  - If the granted master drops valid, this violates TL-UL. The grant is held and no recovery is performed.
- **D_WAIT**
  - Downstream D fields go to both masters. Only the granted master sees `d_valid` = `arb_i_tl_d_valid`.
  - `arb_o_tl_d_ready` = granted master's `d_ready`.
  - On D fire: `last` ← `grant`, go to IDLE.
- **Pass-through rules**
  - Source IDs pass through unmodified. Routing uses only the latched `grant`.
  - No field is registered. The data path is combinational in A_SEND and D_WAIT.
- **Reset (any time, including mid-transaction)**
  - State → IDLE, `grant` → 0, `last` → 1, watchdog count → 0.
  - A pending downstream response is discarded by IDLE's `d_ready` = 1.

## Timing
- Arbitration latency: 1 cycle. A master's valid sampled high in IDLE produces `arb_o_tl_a_valid` = 1 on the next cycle.
- Minimum transaction: 1 IDLE + 1 A_SEND + 1 D_WAIT = 3 cycles from request to response accept. Back-to-back transactions issue at 3 cycles each.
- Downstream `a_valid` never depends combinationally on `a_ready`. `arb_o_tl_a_valid` depends only on the state register and the granted master's valid.
- Output reset values:
  - all `mN_a_ready` = 0
  - all `mN_d_valid` = 0
  - `arb_o_tl_a_valid` = 0
  - `arb_o_tl_d_ready` = 1
  - all other outputs are the mux of master 0 fields or downstream D fields. These are don't-care while valid is low.
- Simultaneous events:
  - Both masters request in IDLE: the one with `grant` != `last` wins.
  - A new request during D_WAIT waits; it is not queued separately.

## Configuration
Macro: `TL_ARB_TIMEOUT_EN`.
- **Defined:**
  - A 16-bit counter clears on entry to D_WAIT and increments each D_WAIT cycle without D fire.
  - When the count reaches `TIMEOUT`, the arbiter synthesizes one D beat to the granted master: `opcode` = AccessAck if the A opcode was a Put, otherwise AccessAckData; `denied` = 1; `data` = 0; `corrupt` = 0; `source` = latched A source.
  - The synthesized beat is held until that master's `d_ready`, then the arbiter goes to IDLE and updates `last`.
  - A late downstream response is then discarded in IDLE.
  - This feature requires registering the A opcode and source at A fire.
- **Undefined:** there is no counter and no opcode/source registers. D_WAIT waits indefinitely.

## Structure
- In `bli201v32itl_tl_defines.vh`:
  - State encodings `TL_ARB_IDLE` = 2'd0, `TL_ARB_A_SEND` = 2'd1, `TL_ARB_D_WAIT` = 2'd2.
  - TL-UL opcode constants: Get = 4, PutFull = 0, PutPartial = 1, AccessAck = 0, AccessAckData = 1.
- One sub-module, `tl_arb_rr_pick`: combinational 2-way round-robin select, (`req[1:0]`, `last`) → (`gnt_idx`, `any`). The top module owns all state.

## Test plan
- **Single request:** m0 issues Get at addr 0x1000_0000, downstream ready = 1. Expect downstream A valid in cycle 1. Downstream D data 0xDEADBEEF on cycle 3 reaches m0 only; m1 `d_valid` stays 0.
- **Tie:** both masters request on the same cycle after reset. Expect m0 granted first, then m1. A second tie after that grants m0 again.
- **Backpressure:** downstream `a_ready` = 0 for 5 cycles. Expect A fields stable and m0 `a_ready` = 0 for 5 cycles, then a single A fire. Then assert m0 `d_ready` = 0 for 3 cycles: expect `arb_o_tl_d_ready` = 0 for those cycles.
- **Reset mid-transaction:** assert `rst` = 0 in D_WAIT. Expect all valids to drop asynchronously. A downstream D beat arriving after reset is discarded; neither master sees `d_valid`.
- **Timeout** (`TL_ARB_TIMEOUT_EN`, `TIMEOUT` = 8): m1 PutFull with no downstream response. Expect m1 to receive AccessAck with `denied` = 1 when the count reaches 8. A late downstream beat in IDLE is discarded.
- **Fairness soak:** both masters request continuously for 200 transactions. Expect exactly 100 grants each, strictly alternating.

Source files
------------

// File: rtl/tl_ul_arbiter_pkg.sv
// Shared TL-UL field widths, opcode constants, bundle structs and FSM encoding
// for the two-master TL-UL arbiter.
package tl_ul_arbiter_pkg;

    localparam int TL_A_WIDTH_OPCODE  = 3;
    localparam int TL_A_WIDTH_PARAM   = 3;
    localparam int TL_A_WIDTH_SIZE    = 2;
    localparam int TL_A_WIDTH_SOURCE  = 8;
    localparam int TL_A_WIDTH_ADDRESS = 32;
    localparam int TL_A_WIDTH_MASK    = 4;
    localparam int TL_A_WIDTH_DATA    = 32;

    localparam int TL_D_WIDTH_OPCODE  = 3;
    localparam int TL_D_WIDTH_PARAM   = 2;
    localparam int TL_D_WIDTH_SIZE    = 2;
    localparam int TL_D_WIDTH_SOURCE  = 8;
    localparam int TL_D_WIDTH_SINK    = 1;
    localparam int TL_D_WIDTH_DATA    = 32;

    localparam logic [TL_A_WIDTH_OPCODE-1:0] TL_OP_GET         = 3'd4;
    localparam logic [TL_A_WIDTH_OPCODE-1:0] TL_OP_PUT_FULL    = 3'd0;
    localparam logic [TL_A_WIDTH_OPCODE-1:0] TL_OP_PUT_PARTIAL = 3'd1;
    localparam logic [TL_D_WIDTH_OPCODE-1:0] TL_OP_ACK         = 3'd0;
    localparam logic [TL_D_WIDTH_OPCODE-1:0] TL_OP_ACK_DATA    = 3'd1;

    typedef enum logic [1:0] {
        TL_ARB_IDLE   = 2'd0,
        TL_ARB_A_SEND = 2'd1,
        TL_ARB_D_WAIT = 2'd2
    } tl_arb_state_e;

    typedef struct packed {
        logic [TL_A_WIDTH_OPCODE-1:0]  opcode;
        logic [TL_A_WIDTH_PARAM-1:0]   param;
        logic [TL_A_WIDTH_SIZE-1:0]    size;
        logic [TL_A_WIDTH_SOURCE-1:0]  source;
        logic [TL_A_WIDTH_ADDRESS-1:0] address;
        logic [TL_A_WIDTH_MASK-1:0]    mask;
        logic [TL_A_WIDTH_DATA-1:0]    data;
        logic                          corrupt;
    } tl_a_t;

    typedef struct packed {
        logic [TL_D_WIDTH_OPCODE-1:0] opcode;
        logic [TL_D_WIDTH_PARAM-1:0]  param;
        logic [TL_D_WIDTH_SIZE-1:0]   size;
        logic [TL_D_WIDTH_SOURCE-1:0] source;
        logic [TL_D_WIDTH_SINK-1:0]   sink;
        logic                         denied;
        logic [TL_D_WIDTH_DATA-1:0]   data;
        logic                         corrupt;
    } tl_d_t;

    function automatic logic is_put(input logic [TL_A_WIDTH_OPCODE-1:0] opcode);
        return (opcode == TL_OP_PUT_FULL) || (opcode == TL_OP_PUT_PARTIAL);
    endfunction

endpackage

// File: rtl/tl_ul_arbiter_rr_pick.sv
// Combinational two-way round-robin select: on a tie the master not granted
// last time wins; a lone requester always wins.
module tl_arb_rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_idx,
    output logic       any
);

    assign any     = |req;
    assign gnt_idx = (&req) ? ~last : req[1];

endmodule

// File: rtl/tl_ul_arbiter.sv
// Two-master TL-UL arbiter with a single outstanding transaction and
// round-robin grant. Optional D-response watchdog: define TL_ARB_TIMEOUT_EN.
module tl_ul_arbiter
    import tl_ul_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 256
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic [TL_A_WIDTH_OPCODE-1:0]  arb_i_m0_tl_a_opcode,
    input  logic [TL_A_WIDTH_PARAM-1:0]   arb_i_m0_tl_a_param,
    input  logic [TL_A_WIDTH_SIZE-1:0]    arb_i_m0_tl_a_size,
    input  logic [TL_A_WIDTH_SOURCE-1:0]  arb_i_m0_tl_a_source,
    input  logic [TL_A_WIDTH_ADDRESS-1:0] arb_i_m0_tl_a_address,
    input  logic [TL_A_WIDTH_MASK-1:0]    arb_i_m0_tl_a_mask,
    input  logic [TL_A_WIDTH_DATA-1:0]    arb_i_m0_tl_a_data,
    input  logic                          arb_i_m0_tl_a_corrupt,
    input  logic                          arb_i_m0_tl_a_valid,
    output logic                          arb_o_m0_tl_a_ready,
    output logic [TL_D_WIDTH_OPCODE-1:0]  arb_o_m0_tl_d_opcode,
    output logic [TL_D_WIDTH_PARAM-1:0]   arb_o_m0_tl_d_param,
    output logic [TL_D_WIDTH_SIZE-1:0]    arb_o_m0_tl_d_size,
    output logic [TL_D_WIDTH_SOURCE-1:0]  arb_o_m0_tl_d_source,
    output logic [TL_D_WIDTH_SINK-1:0]    arb_o_m0_tl_d_sink,
    output logic                          arb_o_m0_tl_d_denied,
    output logic [TL_D_WIDTH_DATA-1:0]    arb_o_m0_tl_d_data,
    output logic                          arb_o_m0_tl_d_corrupt,
    output logic                          arb_o_m0_tl_d_valid,
    input  logic                          arb_i_m0_tl_d_ready,

    input  logic [TL_A_WIDTH_OPCODE-1:0]  arb_i_m1_tl_a_opcode,
    input  logic [TL_A_WIDTH_PARAM-1:0]   arb_i_m1_tl_a_param,
    input  logic [TL_A_WIDTH_SIZE-1:0]    arb_i_m1_tl_a_size,
    input  logic [TL_A_WIDTH_SOURCE-1:0]  arb_i_m1_tl_a_source,
    input  logic [TL_A_WIDTH_ADDRESS-1:0] arb_i_m1_tl_a_address,
    input  logic [TL_A_WIDTH_MASK-1:0]    arb_i_m1_tl_a_mask,
    input  logic [TL_A_WIDTH_DATA-1:0]    arb_i_m1_tl_a_data,
    input  logic                          arb_i_m1_tl_a_corrupt,
    input  logic                          arb_i_m1_tl_a_valid,
    output logic                          arb_o_m1_tl_a_ready,
    output logic [TL_D_WIDTH_OPCODE-1:0]  arb_o_m1_tl_d_opcode,
    output logic [TL_D_WIDTH_PARAM-1:0]   arb_o_m1_tl_d_param,
    output logic [TL_D_WIDTH_SIZE-1:0]    arb_o_m1_tl_d_size,
    output logic [TL_D_WIDTH_SOURCE-1:0]  arb_o_m1_tl_d_source,
    output logic [TL_D_WIDTH_SINK-1:0]    arb_o_m1_tl_d_sink,
    output logic                          arb_o_m1_tl_d_denied,
    output logic [TL_D_WIDTH_DATA-1:0]    arb_o_m1_tl_d_data,
    output logic                          arb_o_m1_tl_d_corrupt,
    output logic                          arb_o_m1_tl_d_valid,
    input  logic                          arb_i_m1_tl_d_ready,

    output logic [TL_A_WIDTH_OPCODE-1:0]  arb_o_tl_a_opcode,
    output logic [TL_A_WIDTH_PARAM-1:0]   arb_o_tl_a_param,
    output logic [TL_A_WIDTH_SIZE-1:0]    arb_o_tl_a_size,
    output logic [TL_A_WIDTH_SOURCE-1:0]  arb_o_tl_a_source,
    output logic [TL_A_WIDTH_ADDRESS-1:0] arb_o_tl_a_address,
    output logic [TL_A_WIDTH_MASK-1:0]    arb_o_tl_a_mask,
    output logic [TL_A_WIDTH_DATA-1:0]    arb_o_tl_a_data,
    output logic                          arb_o_tl_a_corrupt,
    output logic                          arb_o_tl_a_valid,
    input  logic                          arb_i_tl_a_ready,
    input  logic [TL_D_WIDTH_OPCODE-1:0]  arb_i_tl_d_opcode,
    input  logic [TL_D_WIDTH_PARAM-1:0]   arb_i_tl_d_param,
    input  logic [TL_D_WIDTH_SIZE-1:0]    arb_i_tl_d_size,
    input  logic [TL_D_WIDTH_SOURCE-1:0]  arb_i_tl_d_source,
    input  logic [TL_D_WIDTH_SINK-1:0]    arb_i_tl_d_sink,
    input  logic                          arb_i_tl_d_denied,
    input  logic [TL_D_WIDTH_DATA-1:0]    arb_i_tl_d_data,
    input  logic                          arb_i_tl_d_corrupt,
    input  logic                          arb_i_tl_d_valid,
    output logic                          arb_o_tl_d_ready
);

    tl_arb_state_e state_q;
    logic          grant_q;
    logic          last_q;

    tl_a_t      m_a [2];
    logic [1:0] m_a_valid;
    logic [1:0] m_d_ready;
    tl_a_t      sel_a;
    tl_d_t      d_bus;
    tl_d_t      d_out;
    logic       pick_idx;
    logic       pick_any;
    logic       timed_out;
    logic       d_valid_src;
    logic       a_fire;
    logic       d_done;

    assign m_a[0] = '{arb_i_m0_tl_a_opcode, arb_i_m0_tl_a_param, arb_i_m0_tl_a_size,
                      arb_i_m0_tl_a_source, arb_i_m0_tl_a_address, arb_i_m0_tl_a_mask,
                      arb_i_m0_tl_a_data, arb_i_m0_tl_a_corrupt};
    assign m_a[1] = '{arb_i_m1_tl_a_opcode, arb_i_m1_tl_a_param, arb_i_m1_tl_a_size,
                      arb_i_m1_tl_a_source, arb_i_m1_tl_a_address, arb_i_m1_tl_a_mask,
                      arb_i_m1_tl_a_data, arb_i_m1_tl_a_corrupt};
    assign d_bus  = '{arb_i_tl_d_opcode, arb_i_tl_d_param, arb_i_tl_d_size,
                      arb_i_tl_d_source, arb_i_tl_d_sink, arb_i_tl_d_denied,
                      arb_i_tl_d_data, arb_i_tl_d_corrupt};

    assign m_a_valid = {arb_i_m1_tl_a_valid, arb_i_m0_tl_a_valid};
    assign m_d_ready = {arb_i_m1_tl_d_ready, arb_i_m0_tl_d_ready};

    tl_arb_rr_pick u_pick (
        .req     (m_a_valid),
        .last    (last_q),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    // Downstream A is a pure mux of the granted master; valid never looks at a_ready.
    assign sel_a              = m_a[grant_q];
    assign arb_o_tl_a_opcode  = sel_a.opcode;
    assign arb_o_tl_a_param   = sel_a.param;
    assign arb_o_tl_a_size    = sel_a.size;
    assign arb_o_tl_a_source  = sel_a.source;
    assign arb_o_tl_a_address = sel_a.address;
    assign arb_o_tl_a_mask    = sel_a.mask;
    assign arb_o_tl_a_data    = sel_a.data;
    assign arb_o_tl_a_corrupt = sel_a.corrupt;
    assign arb_o_tl_a_valid   = (state_q == TL_ARB_A_SEND) && m_a_valid[grant_q];

    assign arb_o_m0_tl_a_ready = (state_q == TL_ARB_A_SEND) && !grant_q && arb_i_tl_a_ready;
    assign arb_o_m1_tl_a_ready = (state_q == TL_ARB_A_SEND) &&  grant_q && arb_i_tl_a_ready;

    assign a_fire = arb_o_tl_a_valid && arb_i_tl_a_ready;

`ifdef TL_ARB_TIMEOUT_EN
    logic [15:0]                   wd_cnt_q;
    logic [TL_A_WIDTH_OPCODE-1:0]  a_opcode_q;
    logic [TL_A_WIDTH_SOURCE-1:0]  a_source_q;

    assign timed_out = (state_q == TL_ARB_D_WAIT) && (wd_cnt_q == 16'(TIMEOUT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt_q   <= '0;
            a_opcode_q <= '0;
            a_source_q <= '0;
        end else if (a_fire) begin
            wd_cnt_q   <= '0;
            a_opcode_q <= sel_a.opcode;
            a_source_q <= sel_a.source;
        end else if ((state_q == TL_ARB_D_WAIT) && !timed_out) begin
            wd_cnt_q   <= wd_cnt_q + 16'd1;
        end
    end

    // NOTE: d_out gets a full default before the override so no latch is inferred.
    always_comb begin
        d_out = d_bus;
        if (timed_out) begin
            d_out.opcode  = is_put(a_opcode_q) ? TL_OP_ACK : TL_OP_ACK_DATA;
            d_out.param   = '0;
            d_out.size    = '0;
            d_out.source  = a_source_q;
            d_out.sink    = '0;
            d_out.denied  = 1'b1;
            d_out.data    = '0;
            d_out.corrupt = 1'b0;
        end
    end
`else
    assign timed_out = 1'b0;
    assign d_out     = d_bus;
`endif

    // The synthesized timeout beat stalls the real D channel until IDLE drains it.
    assign d_valid_src      = timed_out || arb_i_tl_d_valid;
    assign d_done           = (state_q == TL_ARB_D_WAIT) && d_valid_src && m_d_ready[grant_q];
    assign arb_o_tl_d_ready = (state_q == TL_ARB_IDLE) ||
                              ((state_q == TL_ARB_D_WAIT) && !timed_out && m_d_ready[grant_q]);

    assign arb_o_m0_tl_d_valid = (state_q == TL_ARB_D_WAIT) && !grant_q && d_valid_src;
    assign arb_o_m1_tl_d_valid = (state_q == TL_ARB_D_WAIT) &&  grant_q && d_valid_src;

    assign {arb_o_m0_tl_d_opcode, arb_o_m0_tl_d_param, arb_o_m0_tl_d_size,
            arb_o_m0_tl_d_source, arb_o_m0_tl_d_sink, arb_o_m0_tl_d_denied,
            arb_o_m0_tl_d_data, arb_o_m0_tl_d_corrupt} = d_out;
    assign {arb_o_m1_tl_d_opcode, arb_o_m1_tl_d_param, arb_o_m1_tl_d_size,
            arb_o_m1_tl_d_source, arb_o_m1_tl_d_sink, arb_o_m1_tl_d_denied,
            arb_o_m1_tl_d_data, arb_o_m1_tl_d_corrupt} = d_out;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= TL_ARB_IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            case (state_q)
                TL_ARB_IDLE: begin
                    if (pick_any) begin
                        grant_q <= pick_idx;
                        state_q <= TL_ARB_A_SEND;
                    end
                end
                TL_ARB_A_SEND: begin
                    if (a_fire) state_q <= TL_ARB_D_WAIT;
                end
                TL_ARB_D_WAIT: begin
                    if (d_done) begin
                        last_q  <= grant_q;
                        state_q <= TL_ARB_IDLE;
                    end
                end
                default: state_q <= TL_ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tl_ul_arbiter.sv
// Directed self-checking bench for tl_ul_arbiter: reset, ties, backpressure,
// mid-transaction reset, fairness soak, and the watchdog when TL_ARB_TIMEOUT_EN is set.
module tb_tl_ul_arbiter;
    import tl_ul_arbiter_pkg::*;

`ifdef TL_ARB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 256;
`endif

    logic clk;
    logic rst;

    logic [TL_A_WIDTH_OPCODE-1:0]  arb_i_m0_tl_a_opcode,  arb_i_m1_tl_a_opcode;
    logic [TL_A_WIDTH_PARAM-1:0]   arb_i_m0_tl_a_param,   arb_i_m1_tl_a_param;
    logic [TL_A_WIDTH_SIZE-1:0]    arb_i_m0_tl_a_size,    arb_i_m1_tl_a_size;
    logic [TL_A_WIDTH_SOURCE-1:0]  arb_i_m0_tl_a_source,  arb_i_m1_tl_a_source;
    logic [TL_A_WIDTH_ADDRESS-1:0] arb_i_m0_tl_a_address, arb_i_m1_tl_a_address;
    logic [TL_A_WIDTH_MASK-1:0]    arb_i_m0_tl_a_mask,    arb_i_m1_tl_a_mask;
    logic [TL_A_WIDTH_DATA-1:0]    arb_i_m0_tl_a_data,    arb_i_m1_tl_a_data;
    logic                          arb_i_m0_tl_a_corrupt, arb_i_m1_tl_a_corrupt;
    logic                          arb_i_m0_tl_a_valid,   arb_i_m1_tl_a_valid;
    logic                          arb_o_m0_tl_a_ready,   arb_o_m1_tl_a_ready;
    logic [TL_D_WIDTH_OPCODE-1:0]  arb_o_m0_tl_d_opcode,  arb_o_m1_tl_d_opcode;
    logic [TL_D_WIDTH_PARAM-1:0]   arb_o_m0_tl_d_param,   arb_o_m1_tl_d_param;
    logic [TL_D_WIDTH_SIZE-1:0]    arb_o_m0_tl_d_size,    arb_o_m1_tl_d_size;
    logic [TL_D_WIDTH_SOURCE-1:0]  arb_o_m0_tl_d_source,  arb_o_m1_tl_d_source;
    logic [TL_D_WIDTH_SINK-1:0]    arb_o_m0_tl_d_sink,    arb_o_m1_tl_d_sink;
    logic                          arb_o_m0_tl_d_denied,  arb_o_m1_tl_d_denied;
    logic [TL_D_WIDTH_DATA-1:0]    arb_o_m0_tl_d_data,    arb_o_m1_tl_d_data;
    logic                          arb_o_m0_tl_d_corrupt, arb_o_m1_tl_d_corrupt;
    logic                          arb_o_m0_tl_d_valid,   arb_o_m1_tl_d_valid;
    logic                          arb_i_m0_tl_d_ready,   arb_i_m1_tl_d_ready;

    logic [TL_A_WIDTH_OPCODE-1:0]  arb_o_tl_a_opcode;
    logic [TL_A_WIDTH_PARAM-1:0]   arb_o_tl_a_param;
    logic [TL_A_WIDTH_SIZE-1:0]    arb_o_tl_a_size;
    logic [TL_A_WIDTH_SOURCE-1:0]  arb_o_tl_a_source;
    logic [TL_A_WIDTH_ADDRESS-1:0] arb_o_tl_a_address;
    logic [TL_A_WIDTH_MASK-1:0]    arb_o_tl_a_mask;
    logic [TL_A_WIDTH_DATA-1:0]    arb_o_tl_a_data;
    logic                          arb_o_tl_a_corrupt;
    logic                          arb_o_tl_a_valid;
    logic                          arb_i_tl_a_ready;
    logic [TL_D_WIDTH_OPCODE-1:0]  arb_i_tl_d_opcode;
    logic [TL_D_WIDTH_PARAM-1:0]   arb_i_tl_d_param;
    logic [TL_D_WIDTH_SIZE-1:0]    arb_i_tl_d_size;
    logic [TL_D_WIDTH_SOURCE-1:0]  arb_i_tl_d_source;
    logic [TL_D_WIDTH_SINK-1:0]    arb_i_tl_d_sink;
    logic                          arb_i_tl_d_denied;
    logic [TL_D_WIDTH_DATA-1:0]    arb_i_tl_d_data;
    logic                          arb_i_tl_d_corrupt;
    logic                          arb_i_tl_d_valid;
    logic                          arb_o_tl_d_ready;

    tl_ul_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .arb_i_m0_tl_a_opcode(arb_i_m0_tl_a_opcode), .arb_i_m0_tl_a_param(arb_i_m0_tl_a_param),
        .arb_i_m0_tl_a_size(arb_i_m0_tl_a_size), .arb_i_m0_tl_a_source(arb_i_m0_tl_a_source),
        .arb_i_m0_tl_a_address(arb_i_m0_tl_a_address), .arb_i_m0_tl_a_mask(arb_i_m0_tl_a_mask),
        .arb_i_m0_tl_a_data(arb_i_m0_tl_a_data), .arb_i_m0_tl_a_corrupt(arb_i_m0_tl_a_corrupt),
        .arb_i_m0_tl_a_valid(arb_i_m0_tl_a_valid), .arb_o_m0_tl_a_ready(arb_o_m0_tl_a_ready),
        .arb_o_m0_tl_d_opcode(arb_o_m0_tl_d_opcode), .arb_o_m0_tl_d_param(arb_o_m0_tl_d_param),
        .arb_o_m0_tl_d_size(arb_o_m0_tl_d_size), .arb_o_m0_tl_d_source(arb_o_m0_tl_d_source),
        .arb_o_m0_tl_d_sink(arb_o_m0_tl_d_sink), .arb_o_m0_tl_d_denied(arb_o_m0_tl_d_denied),
        .arb_o_m0_tl_d_data(arb_o_m0_tl_d_data), .arb_o_m0_tl_d_corrupt(arb_o_m0_tl_d_corrupt),
        .arb_o_m0_tl_d_valid(arb_o_m0_tl_d_valid), .arb_i_m0_tl_d_ready(arb_i_m0_tl_d_ready),
        .arb_i_m1_tl_a_opcode(arb_i_m1_tl_a_opcode), .arb_i_m1_tl_a_param(arb_i_m1_tl_a_param),
        .arb_i_m1_tl_a_size(arb_i_m1_tl_a_size), .arb_i_m1_tl_a_source(arb_i_m1_tl_a_source),
        .arb_i_m1_tl_a_address(arb_i_m1_tl_a_address), .arb_i_m1_tl_a_mask(arb_i_m1_tl_a_mask),
        .arb_i_m1_tl_a_data(arb_i_m1_tl_a_data), .arb_i_m1_tl_a_corrupt(arb_i_m1_tl_a_corrupt),
        .arb_i_m1_tl_a_valid(arb_i_m1_tl_a_valid), .arb_o_m1_tl_a_ready(arb_o_m1_tl_a_ready),
        .arb_o_m1_tl_d_opcode(arb_o_m1_tl_d_opcode), .arb_o_m1_tl_d_param(arb_o_m1_tl_d_param),
        .arb_o_m1_tl_d_size(arb_o_m1_tl_d_size), .arb_o_m1_tl_d_source(arb_o_m1_tl_d_source),
        .arb_o_m1_tl_d_sink(arb_o_m1_tl_d_sink), .arb_o_m1_tl_d_denied(arb_o_m1_tl_d_denied),
        .arb_o_m1_tl_d_data(arb_o_m1_tl_d_data), .arb_o_m1_tl_d_corrupt(arb_o_m1_tl_d_corrupt),
        .arb_o_m1_tl_d_valid(arb_o_m1_tl_d_valid), .arb_i_m1_tl_d_ready(arb_i_m1_tl_d_ready),
        .arb_o_tl_a_opcode(arb_o_tl_a_opcode), .arb_o_tl_a_param(arb_o_tl_a_param),
        .arb_o_tl_a_size(arb_o_tl_a_size), .arb_o_tl_a_source(arb_o_tl_a_source),
        .arb_o_tl_a_address(arb_o_tl_a_address), .arb_o_tl_a_mask(arb_o_tl_a_mask),
        .arb_o_tl_a_data(arb_o_tl_a_data), .arb_o_tl_a_corrupt(arb_o_tl_a_corrupt),
        .arb_o_tl_a_valid(arb_o_tl_a_valid), .arb_i_tl_a_ready(arb_i_tl_a_ready),
        .arb_i_tl_d_opcode(arb_i_tl_d_opcode), .arb_i_tl_d_param(arb_i_tl_d_param),
        .arb_i_tl_d_size(arb_i_tl_d_size), .arb_i_tl_d_source(arb_i_tl_d_source),
        .arb_i_tl_d_sink(arb_i_tl_d_sink), .arb_i_tl_d_denied(arb_i_tl_d_denied),
        .arb_i_tl_d_data(arb_i_tl_d_data), .arb_i_tl_d_corrupt(arb_i_tl_d_corrupt),
        .arb_i_tl_d_valid(arb_i_tl_d_valid), .arb_o_tl_d_ready(arb_o_tl_d_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    int   cnt0, cnt1, alt_err, stall, exp_g;
    bit   found;

    initial begin
        rst = 1'b0;
        arb_i_m0_tl_a_opcode = TL_OP_GET; arb_i_m0_tl_a_param = '0; arb_i_m0_tl_a_size = 2'd2;
        arb_i_m0_tl_a_source = 8'h03; arb_i_m0_tl_a_address = 32'h1000_0000;
        arb_i_m0_tl_a_mask = 4'hF; arb_i_m0_tl_a_data = '0; arb_i_m0_tl_a_corrupt = 1'b0;
        arb_i_m0_tl_a_valid = 1'b0; arb_i_m0_tl_d_ready = 1'b1;
        arb_i_m1_tl_a_opcode = TL_OP_GET; arb_i_m1_tl_a_param = '0; arb_i_m1_tl_a_size = 2'd2;
        arb_i_m1_tl_a_source = 8'h5A; arb_i_m1_tl_a_address = 32'h2000_0040;
        arb_i_m1_tl_a_mask = 4'hF; arb_i_m1_tl_a_data = '0; arb_i_m1_tl_a_corrupt = 1'b0;
        arb_i_m1_tl_a_valid = 1'b0; arb_i_m1_tl_d_ready = 1'b1;
        arb_i_tl_a_ready = 1'b1;
        arb_i_tl_d_opcode = TL_OP_ACK_DATA; arb_i_tl_d_param = '0; arb_i_tl_d_size = 2'd2;
        arb_i_tl_d_source = 8'h03; arb_i_tl_d_sink = '0; arb_i_tl_d_denied = 1'b0;
        arb_i_tl_d_data = '0; arb_i_tl_d_corrupt = 1'b0; arb_i_tl_d_valid = 1'b0;

        // Reset values
        #3;
        check("rst_m0_a_ready", arb_o_m0_tl_a_ready, 0);
        check("rst_m1_a_ready", arb_o_m1_tl_a_ready, 0);
        check("rst_m0_d_valid", arb_o_m0_tl_d_valid, 0);
        check("rst_m1_d_valid", arb_o_m1_tl_d_valid, 0);
        check("rst_a_valid",    arb_o_tl_a_valid,    0);
        check("rst_d_ready",    arb_o_tl_d_ready,    1);
        tick(); tick();
        rst = 1'b1;
        settle();

        // Tie after reset: m0, then m1, then m0 again
        tick();
        arb_i_m0_tl_a_valid = 1'b1; arb_i_m1_tl_a_valid = 1'b1;
        settle();
        check("tie1_idle_a_valid", arb_o_tl_a_valid, 0);
        tick();
        check("tie1_m0_ready", arb_o_m0_tl_a_ready, 1);
        check("tie1_m1_ready", arb_o_m1_tl_a_ready, 0);
        check("tie1_addr",     arb_o_tl_a_address, 32'h1000_0000);
        tick();
        arb_i_m0_tl_a_valid = 1'b0;
        arb_i_tl_d_valid = 1'b1; arb_i_tl_d_data = 32'h0000_0111;
        settle();
        check("tie1_m0_d_valid", arb_o_m0_tl_d_valid, 1);
        check("tie1_m1_d_valid", arb_o_m1_tl_d_valid, 0);
        tick();
        arb_i_tl_d_valid = 1'b0; arb_i_m0_tl_a_valid = 1'b1;
        settle();
        check("tie2_idle_a_valid", arb_o_tl_a_valid, 0);
        tick();
        check("tie2_m1_ready", arb_o_m1_tl_a_ready, 1);
        check("tie2_m0_ready", arb_o_m0_tl_a_ready, 0);
        check("tie2_addr",     arb_o_tl_a_address, 32'h2000_0040);
        check("tie2_source",   arb_o_tl_a_source,  8'h5A);
        tick();
        arb_i_m1_tl_a_valid = 1'b0;
        arb_i_tl_d_valid = 1'b1; arb_i_tl_d_source = 8'h5A;
        settle();
        check("tie2_m1_d_valid", arb_o_m1_tl_d_valid, 1);
        check("tie2_m0_d_valid", arb_o_m0_tl_d_valid, 0);
        check("tie2_d_source",   arb_o_m1_tl_d_source, 8'h5A);
        tick();
        arb_i_tl_d_valid = 1'b0; arb_i_m1_tl_a_valid = 1'b1;
        settle();
        tick();
        check("tie3_m0_ready", arb_o_m0_tl_a_ready, 1);
        check("tie3_m1_ready", arb_o_m1_tl_a_ready, 0);
        tick();
        arb_i_m0_tl_a_valid = 1'b0; arb_i_m1_tl_a_valid = 1'b0;
        arb_i_tl_d_valid = 1'b1;
        settle();
        tick();
        arb_i_tl_d_valid = 1'b0;
        settle();

        // Single Get from m0 with 5 cycles of A backpressure and 3 of D backpressure
        tick();
        arb_i_m0_tl_a_valid = 1'b1; arb_i_tl_a_ready = 1'b0;
        settle();
        check("single_idle_a_valid", arb_o_tl_a_valid, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_a_valid",  arb_o_tl_a_valid, 1);
            check("bp_a_addr",   arb_o_tl_a_address, 32'h1000_0000);
            check("bp_m0_ready", arb_o_m0_tl_a_ready, 0);
            tick();
        end
        arb_i_tl_a_ready = 1'b1;
        settle();
        check("bp_release_m0_ready", arb_o_m0_tl_a_ready, 1);
        check("bp_release_opcode",   arb_o_tl_a_opcode, TL_OP_GET);
        tick();
        arb_i_m0_tl_a_valid = 1'b0; arb_i_m0_tl_d_ready = 1'b0;
        arb_i_tl_d_valid = 1'b1; arb_i_tl_d_data = 32'hDEAD_BEEF; arb_i_tl_d_source = 8'h03;
        settle();
        check("dwait_a_valid", arb_o_tl_a_valid, 0);
        for (int i = 0; i < 3; i++) begin
            check("dbp_d_ready",    arb_o_tl_d_ready, 0);
            check("dbp_m0_d_valid", arb_o_m0_tl_d_valid, 1);
            check("dbp_m1_d_valid", arb_o_m1_tl_d_valid, 0);
            tick();
        end
        arb_i_m0_tl_d_ready = 1'b1;
        settle();
        check("single_d_ready", arb_o_tl_d_ready, 1);
        check("single_d_data",  arb_o_m0_tl_d_data, 32'hDEAD_BEEF);
        tick();
        arb_i_tl_d_valid = 1'b0;
        settle();
        check("single_done_m0_d_valid", arb_o_m0_tl_d_valid, 0);
        check("single_done_d_ready",    arb_o_tl_d_ready, 1);

        // Reset in D_WAIT: outputs drop at once and a later D beat is discarded
        tick();
        arb_i_m0_tl_a_valid = 1'b1;
        settle();
        tick();
        tick();
        arb_i_m0_tl_a_valid = 1'b0; arb_i_m0_tl_d_ready = 1'b0; arb_i_tl_d_valid = 1'b1;
        settle();
        check("mid_pre_m0_d_valid", arb_o_m0_tl_d_valid, 1);
        rst = 1'b0;
        settle();
        check("mid_rst_m0_d_valid", arb_o_m0_tl_d_valid, 0);
        check("mid_rst_a_valid",    arb_o_tl_a_valid, 0);
        check("mid_rst_d_ready",    arb_o_tl_d_ready, 1);
        tick();
        rst = 1'b1;
        settle();
        check("post_rst_m0_d_valid", arb_o_m0_tl_d_valid, 0);
        check("post_rst_m1_d_valid", arb_o_m1_tl_d_valid, 0);
        check("post_rst_d_ready",    arb_o_tl_d_ready, 1);
        tick();
        arb_i_tl_d_valid = 1'b0; arb_i_m0_tl_d_ready = 1'b1;
        settle();

        // Fairness soak: 200 transactions with both masters always requesting
        cnt0 = 0; cnt1 = 0; alt_err = 0; stall = 0; exp_g = 0;
        arb_i_m0_tl_a_valid = 1'b1; arb_i_m1_tl_a_valid = 1'b1; arb_i_tl_d_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            found = 1'b0;
            for (int w = 0; w < 5 && !found; w++) begin
                tick();
                if (arb_o_tl_a_valid) found = 1'b1;
            end
            if (!found) begin
                stall++;
            end else begin
                if (arb_o_m1_tl_a_ready) cnt1++; else cnt0++;
                if (int'(arb_o_m1_tl_a_ready) != exp_g) alt_err++;
                exp_g ^= 1;
            end
        end
        check("soak_stall",   stall, 0);
        check("soak_m0",      cnt0, 100);
        check("soak_m1",      cnt1, 100);
        check("soak_alt_err", alt_err, 0);
        tick();
        arb_i_m0_tl_a_valid = 1'b0; arb_i_m1_tl_a_valid = 1'b0;
        settle();
        tick();
        arb_i_tl_d_valid = 1'b0;
        settle();
        tick();

`ifdef TL_ARB_TIMEOUT_EN
        // Watchdog: m1 PutFull with no downstream response
        arb_i_m1_tl_a_opcode = TL_OP_PUT_FULL; arb_i_m1_tl_a_valid = 1'b1;
        arb_i_m1_tl_d_ready = 1'b0;
        settle();
        tick();
        tick();
        arb_i_m1_tl_a_valid = 1'b0;
        settle();
        for (int k = 0; k < 8; k++) begin
            check("to_wait_m1_d_valid", arb_o_m1_tl_d_valid, 0);
            tick();
        end
        check("to_m1_d_valid", arb_o_m1_tl_d_valid, 1);
        check("to_m0_d_valid", arb_o_m0_tl_d_valid, 0);
        check("to_opcode",     arb_o_m1_tl_d_opcode, TL_OP_ACK);
        check("to_denied",     arb_o_m1_tl_d_denied, 1);
        check("to_data",       arb_o_m1_tl_d_data, 0);
        check("to_source",     arb_o_m1_tl_d_source, 8'h5A);
        tick();
        check("to_hold_m1_d_valid", arb_o_m1_tl_d_valid, 1);
        arb_i_m1_tl_d_ready = 1'b1;
        settle();
        tick();
        arb_i_tl_d_valid = 1'b1;
        settle();
        check("to_late_m1_d_valid", arb_o_m1_tl_d_valid, 0);
        check("to_late_d_ready",    arb_o_tl_d_ready, 1);
        tick();
        arb_i_tl_d_valid = 1'b0;
        settle();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
